// File: rtl/reset_sequencer_pkg.sv
// Shared types for the SoC reset sequencer.
// States, reset causes and counter sizing.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD,
    STRETCH,
    RELEASE,
    RUN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_LOCK = 2'd1,
    CAUSE_BTN  = 2'd2
  } cause_t;

  // Width of a counter that must reach max(a,b,c)-1.
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_btn_debounce.sv
// Button synchronizer and debouncer.
// Level flips only after the input is stable long enough.
module btn_debounce
  import reset_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset_i,
  input  logic btn_i,
  output logic level_o
);

  localparam int CW =
    cnt_width(DEBOUNCE_CYCLES, 1, 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop sync, then count cycles of disagreement.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      cnt     <= '0;
      level_o <= 1'b0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
      if (s2 == level_o) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level_o <= ~level_o;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: qualifies lock and button,
// stretches reset, then releases domains in order.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_DOMAINS       = 2,
  parameter int STRETCH_CYCLES  = 32,
  parameter int STAGE_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic                 pll_locked_i,
  input  logic                 btn_i,
  output logic [N_DOMAINS-1:0] rst_o,
  output logic                 ready_o,
  output logic [1:0]           cause_o
);

  localparam int CW = cnt_width(
    STRETCH_CYCLES, STAGE_CYCLES, DEBOUNCE_CYCLES);
  localparam int IW =
    (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [CW-1:0] STRETCH_LAST =
    CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] STAGE_LAST =
    CW'(STAGE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(N_DOMAINS - 1);

  state_t        state;
  cause_t        cause_q;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          lock_s1;
  logic          lock_s2;
  logic          btn_lvl;
  logic          abort;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .reset_i(reset_i),
    .btn_i  (btn_i),
    .level_o(btn_lvl)
  );

  assign abort   = !lock_s2 || btn_lvl;
  assign cause_o = cause_q;

  // Lock sync plus the sequencing state machine.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      lock_s1 <= 1'b0;
      lock_s2 <= 1'b0;
      state   <= HOLD;
      rst_o   <= '1;
      ready_o <= 1'b0;
      cause_q <= CAUSE_POR;
      cnt     <= '0;
      idx     <= '0;
    end else begin
      lock_s1 <= pll_locked_i;
      lock_s2 <= lock_s1;
      if (state != HOLD && abort) begin
        state   <= HOLD;
        rst_o   <= '1;
        ready_o <= 1'b0;
        cnt     <= '0;
        idx     <= '0;
        cause_q <= !lock_s2 ? CAUSE_LOCK
                            : CAUSE_BTN;
      end else begin
        unique case (state)
          HOLD: begin
            rst_o   <= '1;
            ready_o <= 1'b0;
            if (!abort) begin
              state <= STRETCH;
              cnt   <= '0;
            end
          end
          STRETCH: begin
            if (cnt == STRETCH_LAST) begin
              rst_o <= rst_o << 1;
              idx   <= IW'(1);
              cnt   <= '0;
              if (N_DOMAINS == 1) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RELEASE: begin
            if (cnt == STAGE_LAST) begin
              rst_o <= rst_o << 1;
              cnt   <= '0;
              if (idx == IDX_LAST) begin
                state   <= RUN;
                ready_o <= 1'b1;
                idx     <= '0;
              end else begin
                idx <= idx + IW'(1);
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          RUN: begin
            rst_o   <= '0;
            ready_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: timed expectations
// are queued per edge and checked after each edge.
module tb_reset_sequencer;

  logic       clk;
  logic       reset_i;
  logic       pll_locked_i;
  logic       btn_i;
  logic [1:0] rst_o;
  logic       ready_o;
  logic [1:0] cause_o;

  reset_sequencer #(
    .N_DOMAINS      (2),
    .STRETCH_CYCLES (32),
    .STAGE_CYCLES   (16),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .pll_locked_i(pll_locked_i),
    .btn_i       (btn_i),
    .rst_o       (rst_o),
    .ready_o     (ready_o),
    .cause_o     (cause_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         at_edge;
    logic [1:0] rst;
    logic       rdy;
    logic [1:0] cause;
    string      name;
  } exp_t;

  typedef struct {
    int         off;
    logic [1:0] rst;
    logic       rdy;
  } seq_t;

  exp_t sb[$];
  seq_t seq_tab[8];
  int   e;
  int   n_cmp;
  int   n_bad;

  task automatic expect_at(
    input int at,
    input logic [1:0] r,
    input logic rd,
    input logic [1:0] c,
    input string nm
  );
    exp_t x;
    int i;
    x.at_edge = at;
    x.rst = r;
    x.rdy = rd;
    x.cause = c;
    x.name = nm;
    i = 0;
    while (i < sb.size() && sb[i].at_edge <= at)
      i++;
    sb.insert(i, x);
  endtask

  // Staged release relative to STRETCH entry s.
  task automatic push_seq(
    input int s,
    input logic [1:0] c,
    input int max_off,
    input string nm
  );
    for (int i = 0; i < 8; i++) begin
      if (seq_tab[i].off <= max_off)
        expect_at(s + seq_tab[i].off,
                  seq_tab[i].rst,
                  seq_tab[i].rdy, c, nm);
    end
  endtask

  task automatic check_sb();
    exp_t x;
    n_cmp++;
    if (rst_o === 2'b01) begin
      n_bad++;
      $display("FAIL order @edge %0d: rst=%b",
               e, rst_o);
    end
    while (sb.size() > 0 && sb[0].at_edge <= e) begin
      x = sb.pop_front();
      n_cmp++;
      if (x.at_edge != e ||
          {rst_o, ready_o, cause_o} !==
          {x.rst, x.rdy, x.cause}) begin
        n_bad++;
        $display({"FAIL %s @edge %0d: got rst=%b ",
                  "ready=%b cause=%0d, want rst=%b ",
                  "ready=%b cause=%0d"},
                 x.name, x.at_edge, rst_o, ready_o,
                 cause_o, x.rst, x.rdy, x.cause);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
    check_sb();
  endtask

  task automatic run_to(input int t);
    while (e < t) tick();
  endtask

  int r, t, s, a;

  initial begin
    seq_tab[0] = '{0,  2'b11, 1'b0};
    seq_tab[1] = '{1,  2'b11, 1'b0};
    seq_tab[2] = '{31, 2'b11, 1'b0};
    seq_tab[3] = '{32, 2'b10, 1'b0};
    seq_tab[4] = '{33, 2'b10, 1'b0};
    seq_tab[5] = '{47, 2'b10, 1'b0};
    seq_tab[6] = '{48, 2'b00, 1'b1};
    seq_tab[7] = '{49, 2'b00, 1'b1};
    e = 0;
    n_cmp = 0;
    n_bad = 0;
    reset_i = 1'b1;
    pll_locked_i = 1'b1;
    btn_i = 1'b0;

    // Power-on release
    expect_at(1, 2'b11, 1'b0, 2'd0, "reset_state");
    expect_at(4, 2'b11, 1'b0, 2'd0, "reset_state");
    run_to(4);
    reset_i = 1'b0;
    r = 4;
    expect_at(r + 1, 2'b11, 1'b0, 2'd0, "por_sync");
    expect_at(r + 2, 2'b11, 1'b0, 2'd0, "por_sync");
    push_seq(r + 3, 2'd0, 99, "por_seq");
    run_to(r + 55);

    // Single-cycle lock glitch in RUN
    t = e + 4;
    expect_at(t + 1, 2'b00, 1'b1, 2'd0, "glitch_lag");
    expect_at(t + 2, 2'b11, 1'b0, 2'd1, "glitch_abort");
    push_seq(t + 3, 2'd1, 99, "glitch_seq");
    run_to(t - 1);
    pll_locked_i = 1'b0;
    run_to(t);
    pll_locked_i = 1'b1;
    run_to(t + 55);

    // Short bounce is ignored
    t = e + 2;
    for (int k = 0; k < 16; k++)
      expect_at(t + k, 2'b00, 1'b1, 2'd1, "bounce");
    run_to(t - 1);
    btn_i = 1'b1;
    run_to(t + 4);
    btn_i = 1'b0;
    run_to(t + 16);

    // Debounced press, lock glitch while in HOLD
    t = e + 2;
    s = t + 30;
    expect_at(t + 9, 2'b00, 1'b1, 2'd1, "press_lag");
    expect_at(t + 10, 2'b11, 1'b0, 2'd2, "press_abort");
    expect_at(t + 17, 2'b11, 1'b0, 2'd2, "hold_glitch");
    expect_at(t + 29, 2'b11, 1'b0, 2'd2, "press_hold");
    push_seq(s, 2'd2, 1, "press_seq");
    expect_at(s + 10, 2'b11, 1'b0, 2'd2, "press_seq");
    run_to(t - 1);
    btn_i = 1'b1;
    run_to(t + 13);
    pll_locked_i = 1'b0;
    run_to(t + 14);
    pll_locked_i = 1'b1;
    run_to(t + 19);
    btn_i = 1'b0;

    // reset_i during STRETCH with counter at 10
    run_to(s + 10);
    expect_at(s + 11, 2'b11, 1'b0, 2'd0, "rst_mid");
    reset_i = 1'b1;
    run_to(s + 11);
    reset_i = 1'b0;
    r = s + 11;
    expect_at(r + 2, 2'b11, 1'b0, 2'd0, "rst_sync");
    s = r + 3;
    push_seq(s, 2'd0, 33, "rst_seq");

    // Lock loss and press land together in RELEASE
    a = s + 40;
    expect_at(a - 1, 2'b10, 1'b0, 2'd0, "pre_dual");
    expect_at(a, 2'b11, 1'b0, 2'd1, "dual_abort");
    expect_at(a + 10, 2'b11, 1'b0, 2'd1, "dual_hold");
    expect_at(a + 19, 2'b11, 1'b0, 2'd1, "dual_hold_btn");
    push_seq(a + 20, 2'd1, 99, "dual_seq");
    run_to(a - 11);
    btn_i = 1'b1;
    run_to(a - 3);
    pll_locked_i = 1'b0;
    run_to(a + 3);
    pll_locked_i = 1'b1;
    run_to(a + 9);
    btn_i = 1'b0;
    run_to(a + 72);

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d left, want 0",
               sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
